// File: rtl/audio_sdm_dac.sv
// audio_sdm_dac: 2-entry sample FIFO feeding a first-order sigma-delta 1-bit audio DAC
// at a fixed sample rate of clk/SAMPLE_DIV.
module audio_sdm_dac #(
  parameter int DATA_W = 16,
  parameter int SAMPLE_DIV = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              audio_out,
  output logic              sample_tick,
  output logic              underrun
);
  localparam int CW = $clog2(SAMPLE_DIV);
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] mem [2];
  logic wr_ptr, rd_ptr;
  logic [1:0] count;
  logic [DATA_W-1:0] cur, acc, u;
  logic [DATA_W:0] sum;
  logic push, pop;
  // Pulses are gated by rst so a reset edge never doubles as a tick.
  always_comb begin
    s_ready = !rst && count != 2'd2;
    sample_tick = !rst && cnt == CW'(SAMPLE_DIV - 1);
    underrun = sample_tick && count == 2'd0;
    push = s_valid && s_ready;
    pop = sample_tick && count != 2'd0;
    u = {~cur[DATA_W-1], cur[DATA_W-2:0]};
    sum = {1'b0, acc} + {1'b0, u};
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= s_data;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
      cur <= '0;
      acc <= '0;
      audio_out <= 1'b0;
    end else begin
      cnt <= sample_tick ? '0 : cnt + CW'(1);
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      if (pop) cur <= mem[rd_ptr];
      count <= count + {1'b0, push} - {1'b0, pop};
      acc <= sum[DATA_W-1:0];
      audio_out <= sum[DATA_W];
    end
endmodule

// File: tb/tb_audio_sdm_dac.sv
// tb_audio_sdm_dac: scoreboard bench; accepted samples queue up and are popped at each tick
// into a reference modulator that predicts audio_out, tick and underrun.
module tb_audio_sdm_dac;
  localparam int DIV = 250;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic s_ready, audio_out, sample_tick, underrun;
  logic rst2 = 1'b1, s_valid2 = 1'b0;
  logic [15:0] s_data2 = '0;
  logic s_ready2, audio_out2, sample_tick2, underrun2;
  int checks = 0, failures = 0;
  logic [15:0] q [$];
  logic [15:0] m_cur = '0, m_acc = '0, last_pop = '0;
  logic m_out = 1'b0, popped = 1'b0;
  int m_cnt = 0;
  logic [15:0] seq [3] = '{16'd1, 16'd2, 16'd3};

  always #5 clk = ~clk;

  audio_sdm_dac #(.DATA_W(16), .SAMPLE_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .audio_out(audio_out), .sample_tick(sample_tick), .underrun(underrun));

  audio_sdm_dac #(.DATA_W(16), .SAMPLE_DIV(2)) dut2 (
    .clk(clk), .rst(rst2), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .audio_out(audio_out2), .sample_tick(sample_tick2), .underrun(underrun2));

  function automatic logic exp_ready();
    return !rst && q.size() < 2;
  endfunction
  function automatic logic exp_tick();
    return !rst && m_cnt == DIV - 1;
  endfunction
  function automatic logic exp_under();
    return exp_tick() && q.size() == 0;
  endfunction

  task automatic step();
    logic push, tk;
    logic [16:0] sum;
    @(posedge clk);
    popped = 1'b0;
    if (rst) begin
      m_cnt = 0; q.delete(); m_cur = '0; m_acc = '0; m_out = 1'b0;
    end else begin
      push = s_valid && q.size() < 2;
      tk = m_cnt == DIV - 1;
      sum = {1'b0, m_acc} + {1'b0, m_cur ^ 16'h8000};
      m_acc = sum[15:0];
      m_out = sum[16];
      if (tk && q.size() != 0) begin
        last_pop = q.pop_front(); m_cur = last_pop; popped = 1'b1;
      end
      if (push) q.push_back(s_data);
      m_cnt = tk ? 0 : m_cnt + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 16'h7FFF;
    step(); step();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", s_ready); end
    checks++; if (sample_tick !== 1'b0 || underrun !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", sample_tick, underrun); end
    checks++; if (audio_out !== 1'b0) begin failures++; $display("FAIL reset_audio got=%b exp=0", audio_out); end
    checks++; if (dut.cur !== 16'h0) begin failures++; $display("FAIL reset_cur got=%h exp=0000", dut.cur); end
    s_valid = 1'b0; rst = 1'b0; #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_idle();
    int ones = 0, first = -1, ticks = 0;
    for (int i = 0; i <= 65536; i++) begin
      checks++; if (audio_out !== m_out) begin failures++; $display("FAIL idle_audio cyc=%0d got=%b exp=%b", i, audio_out, m_out); end
      checks++; if (sample_tick !== exp_tick() || underrun !== exp_under()) begin failures++; $display("FAIL idle_tick cyc=%0d got=%b%b exp=%b%b", i, sample_tick, underrun, exp_tick(), exp_under()); end
      if (i > 0) ones += int'(audio_out);
      if (sample_tick && first < 0) first = i;
      ticks += int'(sample_tick);
      step();
    end
    checks++; if (ones != 32768) begin failures++; $display("FAIL idle_ones got=%0d exp=32768", ones); end
    checks++; if (first != DIV - 1) begin failures++; $display("FAIL idle_first_tick got=%0d exp=%0d", first, DIV - 1); end
    checks++; if (ticks != 262) begin failures++; $display("FAIL idle_tick_count got=%0d exp=262", ticks); end
  endtask

  task automatic test_full_scale();
    int ones;
    for (int p = 0; p < 2; p++) begin
      do_reset();
      s_valid = 1'b1; s_data = p == 0 ? 16'h7FFF : 16'h8000; ones = 0;
      for (int i = 0; i < DIV + 1003; i++) begin
        checks++; if (audio_out !== m_out) begin failures++; $display("FAIL fs_audio p=%0d cyc=%0d got=%b exp=%b", p, i, audio_out, m_out); end
        checks++; if (s_ready !== exp_ready()) begin failures++; $display("FAIL fs_ready p=%0d cyc=%0d got=%b exp=%b", p, i, s_ready, exp_ready()); end
        if (i > DIV + 2) ones += int'(audio_out);
        step();
      end
      s_valid = 1'b0;
      if (p == 0) begin
        checks++; if (ones < 999) begin failures++; $display("FAIL fs_ones_max got=%0d exp>=999", ones); end
      end else begin
        checks++; if (ones != 0) begin failures++; $display("FAIL fs_ones_min got=%0d exp=0", ones); end
      end
    end
  endtask

  task automatic test_order();
    int k = 0, pn = 0;
    do_reset();
    for (int i = 0; i < 3 * DIV + 2; i++) begin
      s_valid = k < 3; s_data = k < 3 ? seq[k] : 16'h0;
      checks++; if (s_ready !== exp_ready()) begin failures++; $display("FAIL order_ready cyc=%0d got=%b exp=%b", i, s_ready, exp_ready()); end
      if (i == 2) begin
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL order_full got=%b exp=0", s_ready); end
      end
      if (i == DIV) begin
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL order_reopen got=%b exp=1", s_ready); end
      end
      if (s_valid && s_ready) k++;
      step();
      if (popped && pn < 3) begin
        checks++; if (dut.cur !== seq[pn]) begin failures++; $display("FAIL order_pop n=%0d got=%h exp=%h", pn, dut.cur, seq[pn]); end
        pn++;
      end
    end
    s_valid = 1'b0;
    checks++; if (k != 3) begin failures++; $display("FAIL order_accepted got=%0d exp=3", k); end
  endtask

  task automatic test_tick_push();
    do_reset();
    repeat (DIV - 1) step();
    s_valid = 1'b1; s_data = 16'h1234;
    checks++; if (sample_tick !== 1'b1 || underrun !== 1'b1) begin failures++; $display("FAIL tp_underrun got=%b%b exp=11", sample_tick, underrun); end
    step(); s_valid = 1'b0;
    checks++; if (dut.cur !== 16'h0) begin failures++; $display("FAIL tp_no_bypass got=%h exp=0000", dut.cur); end
    repeat (DIV - 1) step();
    checks++; if (sample_tick !== 1'b1 || underrun !== 1'b0) begin failures++; $display("FAIL tp_second_tick got=%b%b exp=10", sample_tick, underrun); end
    step();
    checks++; if (dut.cur !== 16'h1234) begin failures++; $display("FAIL tp_used got=%h exp=1234", dut.cur); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_valid = 1'b1; s_data = 16'hAAAA; step();
    s_data = 16'h5555; step(); s_valid = 1'b0;
    repeat (98) step();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL mid_full got=%b exp=0", s_ready); end
    rst = 1'b1; #1;
    checks++; if (sample_tick !== 1'b0 || underrun !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_cycle got=%b%b%b exp=000", sample_tick, underrun, s_ready); end
    step();
    checks++; if (audio_out !== 1'b0 || dut.cur !== 16'h0) begin failures++; $display("FAIL mid_rst_state got=%b/%h exp=0/0000", audio_out, dut.cur); end
    rst = 1'b0; #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", s_ready); end
    for (int i = 0; i < DIV; i++) begin
      checks++; if (sample_tick !== (i == DIV - 1) || underrun !== (i == DIV - 1)) begin failures++; $display("FAIL mid_tick cyc=%0d got=%b%b", i, sample_tick, underrun); end
      step();
    end
    checks++; if (dut.cur !== 16'h0) begin failures++; $display("FAIL mid_discard got=%h exp=0000", dut.cur); end
    repeat (DIV - 1) step();
    rst = 1'b1; #1;
    checks++; if (sample_tick !== 1'b0 || underrun !== 1'b0) begin failures++; $display("FAIL mid_rst_on_tick got=%b%b exp=00", sample_tick, underrun); end
    step(); rst = 1'b0; #1;
  endtask

  task automatic test_back_to_back();
    rst2 = 1'b1; step(); step(); rst2 = 1'b0; #1;
    for (int i = 0; i < 40; i++) begin
      s_valid2 = i % 2 == 0; s_data2 = 16'(i + 5);
      checks++; if (sample_tick2 !== (i % 2 == 1)) begin failures++; $display("FAIL b2b_tick cyc=%0d got=%b exp=%b", i, sample_tick2, i % 2 == 1); end
      checks++; if (underrun2 !== 1'b0 || s_ready2 !== 1'b1) begin failures++; $display("FAIL b2b_flow cyc=%0d got=%b%b exp=01", i, underrun2, s_ready2); end
      step();
      if (i % 2 == 1) begin
        checks++; if (dut2.cur !== 16'(i + 4)) begin failures++; $display("FAIL b2b_pop cyc=%0d got=%h exp=%h", i, dut2.cur, 16'(i + 4)); end
      end
    end
    s_valid2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_full_scale();
    test_order();
    test_tick_push();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
